mem_burst_initiator: RTL and testbench

- Bus-master front end for the `memory` model. It turns a single request into a correctly timed access on the memory interface.
- A request carries a base address, a burst-size code and a direction:
  - Reads are issued as memory bursts and returned as a word stream.
  - Writes are issued as single-word accesses at incrementing addresses, paced by a write-data stream.
- It sits between the fetch/load-store logic and the memory. It is the initiator for the enable/rd_wr/access_size/busy protocol that the memory answers.

---
 rtl/mem_if_pkg.sv | 36 +++
 rtl/mem_burst_initiator.sv | 163 ++++++++++++++++
 tb/tb_mem_burst_initiator.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// Shared types and helpers for the memory-interface initiator.
package mem_if_pkg;

   typedef enum logic [1:0] {
      SZ_1  = 2'd0,
      SZ_4  = 2'd1,
      SZ_8  = 2'd2,
      SZ_16 = 2'd3
   } size_e;

   // State names carry an ST_ prefix so they do not collide with the
   // RD/WR direction constants below.
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RD       = 2'd1,
      ST_RD_DRAIN = 2'd2,
      ST_WR       = 2'd3
   } state_e;

   localparam logic RD = 1'b1;
   localparam logic WR = 1'b0;

   // Beat count for a burst-size code.
   function automatic logic [4:0] beats(input logic [1:0] size);
      logic [4:0] n;
      case (size)
         SZ_1:    n = 5'd1;
         SZ_4:    n = 5'd4;
         SZ_8:    n = 5'd8;
         SZ_16:   n = 5'd16;
         default: n = 5'd1;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/mem_burst_initiator.sv
// Bus-master front end: turns one request into a read burst or a
// sequence of paced single-word writes on the memory interface.
module mem_burst_initiator
   import mem_if_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [AW-1:0] req_addr,
   input  logic          req_write,
   input  logic [1:0]    req_size,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [DW-1:0] wr_data,
   output logic          rd_valid,
   output logic [DW-1:0] rd_data,
   output logic          rd_last,
   output logic          done,
   output logic          mem_enable,
   output logic          mem_rd_wr,
   output logic [1:0]    mem_access_size,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout,
   input  logic          mem_busy
);

   state_e        state_r, state_nxt_s;
   logic [4:0]    cnt_r, cnt_nxt_s;
   logic [AW-1:0] base_r;
   logic [1:0]    size_r;
   logic [AW-1:0] addr_hold_r;
   logic [DW-1:0] din_hold_r;
   logic          rd_valid_r, rd_last_r, done_r;
   logic [DW-1:0] rd_data_r;

   logic          load_s, last_beat_s, rd_last_s, wr_last_s;
   logic [4:0]    n_s;
   logic          req_ready_s, wr_ready_s, mem_enable_s, mem_rd_wr_s;
   logic [1:0]    mem_access_size_s;
   logic [AW-1:0] mem_addr_s;
   logic [DW-1:0] mem_din_s;

   assign n_s         = beats(size_r);
   assign last_beat_s = (cnt_r == (n_s - 5'd1));

   // Next-state, beat counter and memory-side drive for the current state.
   always_comb begin
      state_nxt_s       = state_r;
      cnt_nxt_s         = cnt_r;
      load_s            = 1'b0;
      rd_last_s         = 1'b0;
      wr_last_s         = 1'b0;
      req_ready_s       = 1'b0;
      wr_ready_s        = 1'b0;
      mem_enable_s      = 1'b0;
      mem_rd_wr_s       = RD;
      mem_access_size_s = 2'd0;
      mem_addr_s        = addr_hold_r;
      mem_din_s         = din_hold_r;
      case (state_r)
         ST_IDLE: begin
            req_ready_s = !mem_busy;
            if (req_valid && !mem_busy) begin
               load_s      = 1'b1;
               cnt_nxt_s   = 5'd0;
               state_nxt_s = req_write ? ST_WR : ST_RD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RD: begin
            mem_enable_s      = 1'b1;
            mem_rd_wr_s       = RD;
            mem_access_size_s = size_r;
            mem_addr_s        = base_r;
            if (last_beat_s) begin
               rd_last_s   = 1'b1;
               cnt_nxt_s   = 5'd0;
               state_nxt_s = ST_RD_DRAIN;
            end else begin
               cnt_nxt_s = cnt_r + 5'd1;
            end
         end
         ST_RD_DRAIN: begin
            state_nxt_s = ST_IDLE;
         end
         ST_WR: begin
            mem_rd_wr_s = WR;
            // Word addresses advance by 4 bytes and wrap naturally.
            mem_addr_s  = base_r + AW'({cnt_r, 2'b00});
            if (wr_valid) begin
               mem_enable_s = 1'b1;
               mem_din_s    = wr_data;
               wr_ready_s   = 1'b1;
               if (last_beat_s) begin
                  wr_last_s   = 1'b1;
                  cnt_nxt_s   = 5'd0;
                  state_nxt_s = ST_IDLE;
               end else begin
                  cnt_nxt_s = cnt_r + 5'd1;
               end
            end else begin
               mem_enable_s = 1'b0;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 5'd0;
         end
      endcase
   end

   // State, request latch, last-driven address/data hold and read-return pipeline.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 5'd0;
         base_r      <= '0;
         size_r      <= 2'd0;
         addr_hold_r <= '0;
         din_hold_r  <= '0;
         rd_valid_r  <= 1'b0;
         rd_data_r   <= '0;
         rd_last_r   <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         if (load_s) begin
            base_r <= req_addr & ~(AW'(3));
            size_r <= req_size;
         end
         if (mem_enable_s) begin
            addr_hold_r <= mem_addr_s;
            din_hold_r  <= mem_din_s;
         end
         rd_valid_r <= mem_enable_s && mem_rd_wr_s;
         if (mem_enable_s && mem_rd_wr_s) begin
            rd_data_r <= mem_dout;
         end
         rd_last_r <= rd_last_s;
         done_r    <= rd_last_s || wr_last_s;
      end
   end

   assign req_ready       = req_ready_s;
   assign wr_ready        = wr_ready_s;
   assign mem_enable      = mem_enable_s;
   assign mem_rd_wr       = mem_rd_wr_s;
   assign mem_access_size = mem_access_size_s;
   assign mem_addr        = mem_addr_s;
   assign mem_din         = mem_din_s;
   assign rd_valid        = rd_valid_r;
   assign rd_data         = rd_data_r;
   assign rd_last         = rd_last_r;
   assign done            = done_r;

endmodule

// File: tb/tb_mem_burst_initiator.sv
// Directed bench for mem_burst_initiator with a small burst-capable memory model.
module tb_mem_burst_initiator;

   logic        clk;
   logic        rst_n;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        wr_valid, wr_ready;
   logic [31:0] wr_data;
   logic        rd_valid, rd_last, done;
   logic [31:0] rd_data;
   logic        mem_enable, mem_rd_wr, mem_busy;
   logic [1:0]  mem_access_size;
   logic [31:0] mem_addr, mem_din, mem_dout;

   int checks = 0;
   int errors = 0;

   mem_burst_initiator #(.AW(32), .DW(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_write(req_write), .req_size(req_size),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .done(done),
      .mem_enable(mem_enable), .mem_rd_wr(mem_rd_wr),
      .mem_access_size(mem_access_size), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_busy(mem_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: 64 words, word i initialised to 0x10000000+i; a read
   // burst returns word (addr/4 + beat) in each enabled cycle.
   logic [31:0] mem [0:63];
   logic [5:0]  rd_beat;
   logic [5:0]  rd_idx;

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i);
         rd_beat <= 6'd0;
      end else begin
         if (mem_enable && !mem_rd_wr) mem[mem_addr[7:2]] <= mem_din;
         if (mem_enable && mem_rd_wr) rd_beat <= rd_beat + 6'd1;
         else rd_beat <= 6'd0;
      end
   end

   always_comb begin
      rd_idx   = mem_addr[7:2] + rd_beat;
      mem_dout = (mem_enable && mem_rd_wr) ? mem[rd_idx] : 32'h0;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   logic [31:0] wr_pat_exp_addr [0:3];
   logic [31:0] wr_pat_exp_data [0:3];
   logic        wr_pat [0:5];
   logic [31:0] wrap_addr [0:3];
   int          beat;

   initial begin
      wr_pat[0] = 1'b1; wr_pat[1] = 1'b0; wr_pat[2] = 1'b1;
      wr_pat[3] = 1'b1; wr_pat[4] = 1'b0; wr_pat[5] = 1'b1;
      wr_pat_exp_addr[0] = 32'h8002_0010; wr_pat_exp_data[0] = 32'hAAAA_EEEE;
      wr_pat_exp_addr[1] = 32'h8002_0014; wr_pat_exp_data[1] = 32'hAAAA_EEF0;
      wr_pat_exp_addr[2] = 32'h8002_0018; wr_pat_exp_data[2] = 32'hAAAA_EEF1;
      wr_pat_exp_addr[3] = 32'h8002_001C; wr_pat_exp_data[3] = 32'hAAAA_EEF3;
      wrap_addr[0] = 32'hFFFF_FFFC; wrap_addr[1] = 32'h0000_0000;
      wrap_addr[2] = 32'h0000_0004; wrap_addr[3] = 32'h0000_0008;

      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
      req_size = 2'd0; wr_valid = 1'b0; wr_data = 32'h0; mem_busy = 1'b0;
      step(); step();
      // Reset state
      chk("rst_enable", 32'(mem_enable), 32'd0);
      chk("rst_rd_wr", 32'(mem_rd_wr), 32'd1);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_wr_ready", 32'(wr_ready), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      rst_n = 1'b1;
      step();

      // 1. Single read
      req_valid = 1'b1; req_addr = 32'h8002_0000; req_size = 2'd0; req_write = 1'b0;
      #1 chk("t1_req_ready", 32'(req_ready), 32'd1);
      step();
      req_valid = 1'b0;
      chk("t1_enable", 32'(mem_enable), 32'd1);
      chk("t1_rd_wr", 32'(mem_rd_wr), 32'd1);
      chk("t1_addr", mem_addr, 32'h8002_0000);
      chk("t1_rd_valid_early", 32'(rd_valid), 32'd0);
      step();
      chk("t1_enable_off", 32'(mem_enable), 32'd0);
      chk("t1_rd_valid", 32'(rd_valid), 32'd1);
      chk("t1_rd_last", 32'(rd_last), 32'd1);
      chk("t1_done", 32'(done), 32'd1);
      chk("t1_rd_data", rd_data, 32'h1000_0000);
      step();
      chk("t1_done_pulse", 32'(done), 32'd0);
      chk("t1_rd_valid_end", 32'(rd_valid), 32'd0);

      // 2. Read burst of 8
      req_valid = 1'b1; req_addr = 32'h8002_0000; req_size = 2'd2; req_write = 1'b0;
      step();
      req_valid = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         chk("t2_enable", 32'(mem_enable), (c <= 8) ? 32'd1 : 32'd0);
         if (c <= 8) begin
            chk("t2_addr", mem_addr, 32'h8002_0000);
            chk("t2_size", 32'(mem_access_size), 32'd2);
         end
         chk("t2_rd_valid", 32'(rd_valid), (c >= 2 && c <= 9) ? 32'd1 : 32'd0);
         if (c >= 2 && c <= 9) chk("t2_rd_data", rd_data, 32'h1000_0000 + 32'(c - 2));
         chk("t2_rd_last", 32'(rd_last), (c == 9) ? 32'd1 : 32'd0);
         chk("t2_done", 32'(done), (c == 9) ? 32'd1 : 32'd0);
         chk("t2_req_ready", 32'(req_ready), (c >= 10) ? 32'd1 : 32'd0);
         step();
      end

      // 3. Write with stalls
      req_valid = 1'b1; req_addr = 32'h8002_0010; req_size = 2'd1; req_write = 1'b1;
      step();
      req_valid = 1'b0;
      beat = 0;
      for (int i = 0; i < 6; i++) begin
         wr_valid = wr_pat[i]; wr_data = 32'hAAAA_EEEE + 32'(i);
         #1;
         chk("t3_enable", 32'(mem_enable), 32'(wr_pat[i]));
         chk("t3_wr_ready", 32'(wr_ready), 32'(wr_pat[i]));
         chk("t3_rd_wr", 32'(mem_rd_wr), 32'd0);
         chk("t3_done_early", 32'(done), 32'd0);
         if (wr_pat[i]) begin
            chk("t3_addr", mem_addr, wr_pat_exp_addr[beat]);
            chk("t3_din", mem_din, wr_pat_exp_data[beat]);
            beat++;
         end
         step();
      end
      wr_valid = 1'b0;
      #1;
      chk("t3_done", 32'(done), 32'd1);
      chk("t3_wr_ready_idle", 32'(wr_ready), 32'd0);
      chk("t3_hold_addr", mem_addr, 32'h8002_001C);
      chk("t3_hold_din", mem_din, 32'hAAAA_EEF3);
      step();
      chk("t3_done_pulse", 32'(done), 32'd0);
      // Read-back of the written words
      req_valid = 1'b1; req_addr = 32'h8002_0010; req_size = 2'd1; req_write = 1'b0;
      step();
      req_valid = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         if (c >= 2) chk("t3_readback", rd_data, wr_pat_exp_data[c - 2]);
         step();
      end

      // 4. Busy gating
      mem_busy = 1'b1;
      req_valid = 1'b1; req_addr = 32'h8002_0008; req_size = 2'd0; req_write = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("t4_req_ready_busy", 32'(req_ready), 32'd0);
         chk("t4_enable_busy", 32'(mem_enable), 32'd0);
         step();
      end
      mem_busy = 1'b0;
      #1 chk("t4_req_ready", 32'(req_ready), 32'd1);
      step();
      req_valid = 1'b0;
      chk("t4_accepted", 32'(mem_enable), 32'd1);
      step();
      chk("t4_done", 32'(done), 32'd1);
      chk("t4_rd_data", rd_data, 32'h1000_0002);
      step();

      // 5. Reset mid-burst
      req_valid = 1'b1; req_addr = 32'h8002_0000; req_size = 2'd3; req_write = 1'b0;
      step();
      req_valid = 1'b0;
      step(); step();
      chk("t5_enable_mid", 32'(mem_enable), 32'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("t5_enable", 32'(mem_enable), 32'd0);
      chk("t5_rd_valid", 32'(rd_valid), 32'd0);
      chk("t5_done", 32'(done), 32'd0);
      chk("t5_req_ready", 32'(req_ready), 32'd1);
      step();
      req_valid = 1'b1; req_addr = 32'h8002_0004; req_size = 2'd0; req_write = 1'b0;
      step();
      req_valid = 1'b0;
      chk("t5_post_enable", 32'(mem_enable), 32'd1);
      step();
      chk("t5_post_done", 32'(done), 32'd1);
      chk("t5_post_rd_data", rd_data, 32'h1000_0001);
      step();

      // 6. Wrap and alignment
      req_valid = 1'b1; req_addr = 32'hFFFF_FFFE; req_size = 2'd1; req_write = 1'b1;
      step();
      req_valid = 1'b0;
      wr_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wr_data = 32'h5500_0000 + 32'(k);
         #1;
         chk("t6_enable", 32'(mem_enable), 32'd1);
         chk("t6_addr", mem_addr, wrap_addr[k]);
         step();
      end
      wr_valid = 1'b0;
      #1;
      chk("t6_done", 32'(done), 32'd1);
      chk("t6_enable_off", 32'(mem_enable), 32'd0);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
